// File: rtl/load_store_unit.sv
// Load/store unit: checks, aligns and extends loads and merges sub-word stores into a
// word-wide data memory with a combinational read port and negedge write commit.
// Optional feature macro: LSU_RMW_EN enables byte/halfword stores through a
// read-modify-write sequence; without it a sub-word store raises exc code 11.

package load_store_unit_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } mem_req_t;
endpackage

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_signed,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        done,
    output logic [31:0] load_data,
    output logic        exc,
    output logic [1:0]  exc_code,
    output mem_req_t    mem_req,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] AddrLimit = 32'(4 * MEM_DEPTH);

`ifdef LSU_RMW_EN
    typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StWrite, StResp} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    // Holds the store data from acceptance; for sub-word stores it becomes the merged word.
    logic [31:0] merge_q, merge_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        exc_q, exc_d;
    logic [1:0]  exc_code_q, exc_code_d;

    logic [1:0]  chk_code;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Acceptance checks in priority order; 00 means the operation is legal.
    always_comb begin
        chk_code = 2'b00;
        if (op_size == 2'b11) begin
            chk_code = 2'b11;
        end
`ifndef LSU_RMW_EN
        else if (op_store && (op_size != 2'b10)) begin
            chk_code = 2'b11;
        end
`endif
        else if ((op_size == 2'b01 && op_addr[0]) ||
                 (op_size == 2'b10 && op_addr[1:0] != 2'b00)) begin
            chk_code = 2'b01;
        end else if (op_addr >= AddrLimit) begin
            chk_code = 2'b10;
        end
    end

    // Little-endian lane selection and sign/zero extension of the read word.
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state logic for the control FSM and all registered outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        merge_d     = merge_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        exc_d       = 1'b0;
        exc_code_d  = exc_code_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (chk_code != 2'b00) begin
                        exc_d      = 1'b1;
                        exc_code_d = chk_code;
                    end else begin
                        addr_d   = op_addr;
                        size_d   = op_size;
                        signed_d = op_signed;
                        if (!op_store) begin
                            state_d = StLoad;
                        end else begin
                            merge_d = op_wdata;
`ifdef LSU_RMW_EN
                            if (op_size != 2'b10) state_d = StRmwRead;
                            else
`endif
                            state_d = StWrite;
                        end
                    end
                end
            end
            StLoad: begin
                load_data_d = ld_ext;
                state_d     = StResp;
            end
`ifdef LSU_RMW_EN
            StRmwRead: begin
                merge_d = mem_rdata;
                if (size_q == 2'b00) begin
                    unique case (addr_q[1:0])
                        2'b00:   merge_d[7:0]   = merge_q[7:0];
                        2'b01:   merge_d[15:8]  = merge_q[7:0];
                        2'b10:   merge_d[23:16] = merge_q[7:0];
                        default: merge_d[31:24] = merge_q[7:0];
                    endcase
                end else if (addr_q[1]) begin
                    merge_d[31:16] = merge_q[15:0];
                end else begin
                    merge_d[15:0] = merge_q[15:0];
                end
                state_d = StWrite;
            end
`endif
            StWrite: state_d = StResp;
            StResp: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // All state, cleared asynchronously so outputs drop without a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            merge_q     <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            exc_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            merge_q     <= merge_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            exc_code_q  <= exc_code_d;
        end
    end

    // Memory request decoded purely from registered state; wen only in WRITE.
    always_comb begin
        mem_req = '0;
        if (state_q != StIdle && state_q != StResp) begin
            mem_req.addr = {addr_q[31:2], 2'b00};
        end
        if (state_q == StWrite) begin
            mem_req.wen   = 1'b1;
            mem_req.wdata = merge_q;
        end
    end

    assign op_ready  = (state_q == StIdle);
    assign done      = done_q;
    assign load_data = load_data_q;
    assign exc       = exc_q;
    assign exc_code  = exc_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random operations and
// pushes the reference-model response; a negedge monitor pops and compares on done/exc.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int unsigned MEM_DEPTH = 2048;
    localparam int unsigned AW = $clog2(MEM_DEPTH);
`ifdef LSU_RMW_EN
    localparam bit RmwEn = 1'b1;
`else
    localparam bit RmwEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  op_size = 2'b00;
    logic        op_signed = 1'b0;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic        op_ready;
    logic        done;
    logic [31:0] load_data;
    logic        exc;
    logic [1:0]  exc_code;
    mem_req_t    mem_req;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_store(op_store),
        .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr), .op_wdata(op_wdata),
        .op_ready(op_ready), .done(done), .load_data(load_data), .exc(exc),
        .exc_code(exc_code), .mem_req(mem_req), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Attached data memory and an independent reference copy.
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] ref_mem [MEM_DEPTH];
    assign mem_rdata = mem[mem_req.addr[AW+1:2]];
    always @(negedge clock) if (mem_req.wen) mem[mem_req.addr[AW+1:2]] <= mem_req.wdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        is_exc;
        logic [1:0]  code;
        logic        is_load;
        logic [31:0] ldata;
        logic        is_store;
        int unsigned widx;
        logic [31:0] wword;
        logic [31:0] waddr;
        int          wens;
        int          exp_cyc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts write strobes and retires one scoreboard entry per done/exc pulse.
    int   wen_cnt = 0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset) begin
            if (mem_req.wen) begin
                wen_cnt++;
                if (sbq.size() == 0) check("wen_unexpected", 1, 0);
                else check("wen_addr", mem_req.addr, sbq[0].waddr);
            end
            if (done || exc) begin
                if (sbq.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("resp_is_exc", exc, mon_e.is_exc);
                    check("resp_latency", cyc, mon_e.exp_cyc);
                    check("wen_count", wen_cnt, mon_e.wens);
                    if (mon_e.is_exc) check("exc_code", exc_code, mon_e.code);
                    if (mon_e.is_load) check("load_data", load_data, mon_e.ldata);
                    if (mon_e.is_store) check("mem_word", mem[mon_e.widx], mon_e.wword);
                end
                wen_cnt = 0;
            end
        end
    end

    // Reference model: computes the response and updates ref_mem from the architectural rules.
    function automatic exp_t model(input logic st, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        logic [31:0] mask, msb, word, val;
        int sh;
        e = '{is_exc: 1'b0, code: 2'b00, is_load: 1'b0, ldata: '0, is_store: 1'b0,
              widx: 0, wword: '0, waddr: '0, wens: 0, exp_cyc: 0};
        if (sz == 2'd3 || (st && sz != 2'd2 && !RmwEn)) e.code = 2'b11;
        else if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) e.code = 2'b01;
        else if (a >= 4 * MEM_DEPTH) e.code = 2'b10;
        if (e.code != 2'b00) begin
            e.is_exc = 1'b1;
            return e;
        end
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        msb  = mask ^ (mask >> 1);
        sh   = int'(a % 4) * 8;
        e.widx  = a / 4;
        e.waddr = a - (a % 4);
        word = ref_mem[e.widx];
        if (!st) begin
            val = (word >> sh) & mask;
            if (sg && (val & msb) != 0) val = val | ~mask;
            e.is_load = 1'b1;
            e.ldata   = val;
            e.exp_cyc = 2;
        end else begin
            word = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[e.widx] = word;
            e.is_store = 1'b1;
            e.wword    = word;
            e.wens     = 1;
            e.exp_cyc  = (sz == 2'd2) ? 2 : 3;
        end
        return e;
    endfunction

    // Driver: called at a negedge; waits for op_ready, presents one op for one edge.
    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int guard = 0;
        while (!op_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!op_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        e = model(st, sz, sg, a, wd);
        e.exp_cyc = cyc + 1 + e.exp_cyc;
        sbq.push_back(e);
        op_valid = 1'b1; op_store = st; op_size = sz; op_signed = sg;
        op_addr = a; op_wdata = wd;
        @(posedge clock);
        #1;
        // While busy, present junk with op_valid high; it must be ignored.
        op_valid = !e.is_exc;
        op_store = 1'($urandom); op_size = 2'($urandom); op_signed = 1'($urandom);
        op_addr = $urandom; op_wdata = $urandom;
        @(negedge clock);
        check("busy_ready", op_ready, e.is_exc);
        op_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sbq.size() != 0 || !op_ready) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (sbq.size() != 0) check("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        #2;
        check("rst_ready", op_ready, 1);
        check("rst_done", done, 0);
        check("rst_exc", exc, 0);
        check("rst_exc_code", exc_code, 0);
        check("rst_load_data", load_data, 0);
        check("rst_mem_req_zero", 32'(mem_req == '0), 1);
        #21 reset = 1'b1;
        @(negedge clock);

        // Directed cases.
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 2'd2, 0, 32'h10, 32'h0);
        drain();
        check("word_load_0x10", load_data, 32'hDEADBEEF);
        issue(1, 2'd2, 0, 32'h20, 32'h11223344);
        issue(0, 2'd0, 1, 32'h23, 32'h0);
        drain();
        check("sbyte_load_0x23", load_data, 32'h00000011);
        issue(0, 2'd1, 1, 32'h20, 32'h0);
        drain();
        check("shalf_load_0x20", load_data, 32'h00003344);
        issue(1, 2'd0, 0, 32'h22, 32'h000000AB);
        drain();
        check("byte_store_0x22", mem[8], RmwEn ? 32'h11AB3344 : 32'h11223344);
        issue(1, 2'd0, 0, 32'h21, 32'h00000080);
        issue(0, 2'd0, 1, 32'h21, 32'h0);
        drain();
        check("sbyte_load_0x21", load_data, RmwEn ? 32'hFFFFFF80 : 32'h00000033);
        issue(0, 2'd1, 0, 32'h21, 32'h0);
        drain();
        check("misaligned_code", exc_code, 2'b01);
        issue(0, 2'd2, 0, 32'(4 * MEM_DEPTH), 32'h0);
        drain();
        check("range_code", exc_code, 2'b10);
        issue(0, 2'd3, 0, 32'h0, 32'h0);
        issue(1, 2'd1, 0, 32'(4 * MEM_DEPTH - 2), 32'h5A5A);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 4 * MEM_DEPTH - 1);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        drain();

        // Reset while in WRITE: the strobe must drop before the negedge commit.
        issue(1, 2'd2, 0, 32'h100, 32'h0);
        drain();
        op_valid = 1'b1; op_store = 1'b1; op_size = 2'd2; op_addr = 32'h40;
        op_wdata = 32'hCAFEF00D;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        check("wen_in_write", mem_req.wen, 1);
        reset = 1'b0;
        #1;
        check("rst_wen_drop", mem_req.wen, 0);
        check("rst_req_zero", 32'(mem_req == '0), 1);
        check("rst_exc_code_clr", exc_code, 0);
        check("rst_load_data_clr", load_data, 0);
        @(negedge clock);
        #1;
        check("rst_mem_unchanged", mem[16], ref_mem[16]);
        reset = 1'b1;
        @(negedge clock);
        check("rst_release_ready", op_ready, 1);
        check("rst_release_done", done, 0);
        issue(0, 2'd2, 0, 32'h40, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
